// File: rtl/status_register.sv
// status_register: CPU status word {I,C,V,Z,N} with masked ALU flag latching,
// branch condition evaluation and an interrupt shadow stack.
//   clk, reset              : rising-edge clock, async active-high reset
//   flags_we, byte_mode,
//   flag_mask, alu_flags,
//   alu_flags8              : masked flag update from 16- or 8-bit ALU result
//   sr_we, bus_in           : direct load of {I,C,V,Z,N} from bus_in[4:0]
//   ie_set, ie_clr          : interrupt enable control
//   push, pop               : interrupt entry / return through the shadow stack
//   cond, cond_true         : branch condition code and its result
//   old_carry, sr_out       : stored carry and status word
//   stack_empty/full/err    : shadow stack state, err is sticky until reset
module status_register #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flags_we,
    input  logic        byte_mode,
    input  logic [3:0]  flag_mask,
    input  logic [3:0]  alu_flags,
    input  logic [3:0]  alu_flags8,
    input  logic        sr_we,
    input  logic [15:0] bus_in,
    input  logic        ie_set,
    input  logic        ie_clr,
    input  logic        push,
    input  logic        pop,
    input  logic [3:0]  cond,
    output logic        cond_true,
    output logic        old_carry,
    output logic [15:0] sr_out,
    output logic        stack_empty,
    output logic        stack_full,
    output logic        stack_err
);
    localparam int SPW = $clog2(DEPTH);

    logic [3:0]     r_flags;
    logic           r_ie;
    logic [SPW:0]   r_sp;
    logic [4:0]     r_stack [DEPTH];
    logic           r_err;
    logic           w_c, w_v, w_z, w_n, w_lt;
    logic [3:0]     w_src;
    logic [SPW-1:0] w_top;
    logic [15:0]    w_cond_vec;
    logic           w_unused;

    assign {w_c, w_v, w_z, w_n} = r_flags;
    assign w_lt        = w_n ^ w_v;
    assign w_src       = byte_mode ? alu_flags8 : alu_flags;
    assign w_top       = r_sp[SPW-1:0] - SPW'(1);
    assign stack_empty = r_sp == '0;
    assign stack_full  = r_sp == (SPW+1)'(DEPTH);
    assign stack_err   = r_err;
    assign old_carry   = w_c;
    assign sr_out      = {11'b0, r_ie, r_flags};
    assign w_unused    = ^bus_in[15:5];

    // One entry per condition code, code 0 at the LSB.
    assign w_cond_vec = {1'b0, ~w_c & ~w_z, w_c | w_z, ~w_z & ~w_lt, w_z | w_lt,
                         ~w_lt, w_lt, ~w_v, w_v, ~w_n, w_n, ~w_c, w_c, ~w_z, w_z, 1'b1};
    assign cond_true  = w_cond_vec[cond];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= '0;
            r_ie    <= 1'b0;
            r_sp    <= '0;
            r_err   <= 1'b0;
            for (int k = 0; k < DEPTH; k++) r_stack[k] <= '0;
        end else if (push && pop) begin
            r_err <= 1'b1;
        end else if (pop) begin
            if (stack_empty) begin
                r_err <= 1'b1;
            end else begin
                r_sp            <= r_sp - 1'b1;
                {r_ie, r_flags} <= r_stack[w_top];
            end
        end else if (push) begin
            r_ie <= 1'b0;
            if (stack_full) begin
                r_err <= 1'b1;
            end else begin
                r_stack[r_sp[SPW-1:0]] <= {r_ie, r_flags};
                r_sp                   <= r_sp + 1'b1;
            end
        end else if (sr_we) begin
            {r_ie, r_flags} <= bus_in[4:0];
        end else begin
            if (flags_we) r_flags <= (flag_mask & w_src) | (~flag_mask & r_flags);
            if (ie_set ^ ie_clr) r_ie <= ie_set;
        end
    end
endmodule

// File: tb/tb_status_register.sv
// tb_status_register: directed vector table, hand sequences and randomized run against a queue-based model.
module tb_status_register;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flags_we = 0, byte_mode = 0, sr_we = 0, ie_set = 0, ie_clr = 0, push = 0, pop = 0;
    logic [3:0]  flag_mask = 0, alu_flags = 0, alu_flags8 = 0, cond = 0;
    logic [15:0] bus_in = 0;
    logic        cond_true, old_carry, stack_empty, stack_full, stack_err;
    logic [15:0] sr_out;

    int checks = 0;
    int failures = 0;

    status_register #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flags_we(flags_we), .byte_mode(byte_mode),
        .flag_mask(flag_mask), .alu_flags(alu_flags), .alu_flags8(alu_flags8),
        .sr_we(sr_we), .bus_in(bus_in), .ie_set(ie_set), .ie_clr(ie_clr),
        .push(push), .pop(pop), .cond(cond), .cond_true(cond_true),
        .old_carry(old_carry), .sr_out(sr_out), .stack_empty(stack_empty),
        .stack_full(stack_full), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fwe, bm;
        logic [3:0]  mask, alu, alu8;
        logic        swe;
        logic [15:0] bus;
        logic        ies, iec, psh, pp;
        logic [3:0]  cnd;
        logic [15:0] e_sr;
        logic        e_emp, e_full, e_err, e_cond;
    } vec_t;

    vec_t tbl [22];

    // Reference model: status word as named bits, shadow stack as a queue.
    logic       m_i, m_c, m_v, m_z, m_n, m_err;
    logic [4:0] m_stack [$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input vec_t v);
        flags_we = v.fwe; byte_mode = v.bm; flag_mask = v.mask; alu_flags = v.alu;
        alu_flags8 = v.alu8; sr_we = v.swe; bus_in = v.bus; ie_set = v.ies;
        ie_clr = v.iec; push = v.psh; pop = v.pp; cond = v.cnd;
    endtask

    task automatic idle();
        vec_t v;
        v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        set_in(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        m_i = 0; m_c = 0; m_v = 0; m_z = 0; m_n = 0; m_err = 0;
        m_stack.delete();
    endtask

    function automatic logic exp_cond(input logic [3:0] cc, input logic c, v, z, n);
        case (cc)
            0: return 1'b1;
            1: return z;
            2: return !z;
            3: return c;
            4: return !c;
            5: return n;
            6: return !n;
            7: return v;
            8: return !v;
            9: return n != v;
            10: return n == v;
            11: return z || (n != v);
            12: return !z && (n == v);
            13: return c || z;
            14: return !c && !z;
            default: return 1'b0;
        endcase
    endfunction

    // Apply the spec rules to the model for the inputs currently driven.
    task automatic model_step();
        logic [3:0] src;
        logic [3:0] f;
        logic [4:0] w;
        if (push && pop) m_err = 1;
        else if (pop) begin
            if (m_stack.size() == 0) m_err = 1;
            else begin
                w = m_stack.pop_back();
                {m_i, m_c, m_v, m_z, m_n} = w;
            end
        end else if (push) begin
            if (m_stack.size() == DEPTH) m_err = 1;
            else m_stack.push_back({m_i, m_c, m_v, m_z, m_n});
            m_i = 0;
        end else if (sr_we) {m_i, m_c, m_v, m_z, m_n} = bus_in[4:0];
        else begin
            src = byte_mode ? alu_flags8 : alu_flags;
            f = {m_c, m_v, m_z, m_n};
            if (flags_we) for (int b = 0; b < 4; b++) if (flag_mask[b]) f[b] = src[b];
            {m_c, m_v, m_z, m_n} = f;
            if (ie_set && !ie_clr) m_i = 1;
            if (ie_clr && !ie_set) m_i = 0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " sr"}, sr_out, {11'b0, m_i, m_c, m_v, m_z, m_n});
        chk({tag, " carry"}, old_carry, m_c);
        chk({tag, " empty"}, stack_empty, m_stack.size() == 0);
        chk({tag, " full"}, stack_full, m_stack.size() == DEPTH);
        chk({tag, " err"}, stack_err, m_err);
        chk({tag, " cond"}, cond_true, exp_cond(cond, m_c, m_v, m_z, m_n));
    endtask

    initial begin
        //          fwe bm mask  alu   alu8  swe bus      ies iec psh pp cnd    e_sr     emp full err cond
        tbl[0]  = '{1, 0, 4'hF, 4'hA, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 4'd3,  16'h000A, 1, 0, 0, 1};
        tbl[1]  = '{1, 1, 4'h3, 4'h0, 4'h5, 0, 16'h0000, 0, 0, 0, 0, 4'd9,  16'h0009, 1, 0, 0, 1};
        tbl[2]  = '{0, 0, 4'h0, 4'h0, 4'h0, 1, 16'h0003, 0, 0, 0, 0, 4'd1,  16'h0003, 1, 0, 0, 1};
        tbl[3]  = '{0, 0, 4'h0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 4'd5,  16'h0003, 1, 0, 0, 1};
        tbl[4]  = '{0, 0, 4'h0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 4'd9,  16'h0003, 1, 0, 0, 1};
        tbl[5]  = '{0, 0, 4'h0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 4'd11, 16'h0003, 1, 0, 0, 1};
        tbl[6]  = '{0, 0, 4'h0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 4'd12, 16'h0003, 1, 0, 0, 0};
        tbl[7]  = '{0, 0, 4'h0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 4'd14, 16'h0003, 1, 0, 0, 0};
        tbl[8]  = '{0, 0, 4'h0, 4'h0, 4'h0, 0, 16'h0000, 1, 0, 0, 0, 4'd0,  16'h0013, 1, 0, 0, 1};
        tbl[9]  = '{0, 0, 4'h0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 1, 0, 4'd15, 16'h0003, 0, 0, 0, 0};
        tbl[10] = '{1, 0, 4'hF, 4'h8, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 4'd3,  16'h0008, 0, 0, 0, 1};
        tbl[11] = '{0, 0, 4'h0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 1, 0, 4'd4,  16'h0008, 0, 0, 0, 0};
        tbl[12] = '{0, 0, 4'h0, 4'h0, 4'h0, 1, 16'h0004, 0, 0, 0, 0, 4'd7,  16'h0004, 0, 0, 0, 1};
        tbl[13] = '{0, 0, 4'h0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 1, 0, 4'd8,  16'h0004, 0, 0, 0, 0};
        tbl[14] = '{1, 0, 4'hF, 4'h2, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 4'd2,  16'h0002, 0, 0, 0, 0};
        tbl[15] = '{0, 0, 4'h0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 1, 0, 4'd13, 16'h0002, 0, 1, 0, 1};
        tbl[16] = '{0, 0, 4'h0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 1, 0, 4'd0,  16'h0002, 0, 1, 1, 1};
        tbl[17] = '{0, 0, 4'h0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 0, 1, 4'd15, 16'h0002, 0, 0, 1, 0};
        tbl[18] = '{0, 0, 4'h0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 0, 1, 4'd7,  16'h0004, 0, 0, 1, 1};
        tbl[19] = '{0, 0, 4'h0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 0, 1, 4'd3,  16'h0008, 0, 0, 1, 1};
        tbl[20] = '{0, 0, 4'h0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 0, 1, 4'd13, 16'h0013, 1, 0, 1, 1};
        tbl[21] = '{0, 0, 4'h0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 0, 1, 4'd10, 16'h0013, 1, 0, 1, 0};

        // Reset state before any clock edge.
        #2;
        chk("rst sr", sr_out, 16'h0000);
        chk("rst carry", old_carry, 1'b0);
        chk("rst empty", stack_empty, 1'b1);
        chk("rst full", stack_full, 1'b0);
        chk("rst err", stack_err, 1'b0);
        chk("rst AL", cond_true, 1'b1);
        cond = 4'd15;
        #1;
        chk("rst NV", cond_true, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 22; k++) begin
            set_in(tbl[k]);
            step();
            chk($sformatf("vec%0d sr", k), sr_out, tbl[k].e_sr);
            chk($sformatf("vec%0d carry", k), old_carry, tbl[k].e_sr[3]);
            chk($sformatf("vec%0d empty", k), stack_empty, tbl[k].e_emp);
            chk($sformatf("vec%0d full", k), stack_full, tbl[k].e_full);
            chk($sformatf("vec%0d err", k), stack_err, tbl[k].e_err);
            chk($sformatf("vec%0d cond", k), cond_true, tbl[k].e_cond);
        end

        // Priority: push wins over sr_we, flags_we and ie_set.
        idle();
        pulse_reset();
        sr_we = 1; bus_in = 16'h0015;
        step();
        idle();
        push = 1; sr_we = 1; bus_in = 16'h001F; flags_we = 1; flag_mask = 4'hF;
        alu_flags = 4'hF; ie_set = 1;
        step();
        chk("prio sr", sr_out, 16'h0005);
        chk("prio empty", stack_empty, 1'b0);
        chk("prio err", stack_err, 1'b0);
        idle();
        push = 1; pop = 1; flags_we = 1; flag_mask = 4'hF; alu_flags = 4'hA;
        step();
        chk("pushpop sr", sr_out, 16'h0005);
        chk("pushpop err", stack_err, 1'b1);
        chk("pushpop empty", stack_empty, 1'b0);
        idle();
        pop = 1;
        step();
        chk("pushpop restore", sr_out, 16'h0015);
        chk("pushpop now empty", stack_empty, 1'b1);

        // ie_set with ie_clr leaves I alone; ie_clr together with flags_we applies both.
        idle();
        ie_set = 1; ie_clr = 1;
        step();
        chk("ie both", sr_out, 16'h0015);
        idle();
        ie_clr = 1; flags_we = 1; flag_mask = 4'h8; alu_flags = 4'h8;
        step();
        chk("ie clr+flags", sr_out, 16'h000D);

        // Async reset between edges after two pushes.
        idle();
        pulse_reset();
        sr_we = 1; bus_in = 16'h001A;
        step();
        idle();
        push = 1;
        step();
        step();
        idle();
        push = 1; pop = 1;
        step();
        idle();
        chk("pre-async err", stack_err, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async sr", sr_out, 16'h0000);
        chk("async empty", stack_empty, 1'b1);
        chk("async full", stack_full, 1'b0);
        chk("async err", stack_err, 1'b0);
        chk("async carry", old_carry, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        pop = 1;
        step();
        idle();
        chk("async stack cleared", sr_out, 16'h0000);

        // Randomized run against the model, with periodic resets.
        idle();
        pulse_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 249) begin
                idle();
                pulse_reset();
            end
            flags_we   = $urandom_range(0, 1);
            byte_mode  = $urandom_range(0, 1);
            flag_mask  = 4'($urandom);
            alu_flags  = 4'($urandom);
            alu_flags8 = 4'($urandom);
            sr_we      = $urandom_range(0, 5) == 0;
            bus_in     = 16'($urandom);
            ie_set     = $urandom_range(0, 3) == 0;
            ie_clr     = $urandom_range(0, 3) == 0;
            push       = $urandom_range(0, 3) == 0;
            pop        = $urandom_range(0, 4) == 0;
            cond       = 4'($urandom);
            model_step();
            step();
            check_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
